// File: rtl/pio_shift_out_pkg.sv
// Shared types and width helpers for the pio_shift_out serializer.
package pio_shift_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  localparam int DEF_DATA_W  = 10;
  localparam int DEF_CLK_DIV = 4;

  // Divider counter width; a CLK_DIV of 1 still needs a one-bit register.
  function automatic int div_cnt_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

  function automatic int bit_cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/pio_shift_out_if.sv
// Parallel PIO word in, three-pin 74HC595 serial link plus busy flag out.
interface pio_shift_out_if #(
  parameter int DATA_W = 10
) ();

  logic [DATA_W-1:0] pio_in;
  logic              sclk;
  logic              sdata;
  logic              slatch;
  logic              busy;

  modport master (
    input  pio_in,
    output sclk,
    output sdata,
    output slatch,
    output busy
  );

  modport slave (
    output pio_in,
    input  sclk,
    input  sdata,
    input  slatch,
    input  busy
  );

endinterface

// File: rtl/pio_shift_tick.sv
// Phase divider: one-cycle phase_tick every CLK_DIV cycles while en is high.
module pio_shift_tick
  import pio_shift_out_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic phase_tick
);

  localparam int                DIV_W = div_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Held at zero while disabled, so every enable starts a fresh phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign phase_tick = en && (div_cnt == LAST);

endmodule

// File: rtl/pio_shift_out.sv
// Serializes the PIO word to a 74HC595 chain whenever it changes.
// Define PIO_SHIFT_OUT_MSB_FIRST_EN to shift MSB first (default LSB first).
module pio_shift_out
  import pio_shift_out_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_shift_out_if.master   bus
);

  localparam int               BIT_W    = bit_cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state;
  logic [DATA_W-1:0] sent_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              init_pend;
  logic [BIT_W-1:0]  bit_cnt;
  logic              first_bit;
  logic              next_bit;
  logic              tick_en;
  logic              phase_tick;
  logic              sclk_q;
  logic              sdata_q;
  logic              slatch_q;
  logic              busy_q;

  assign tick_en = (state != IDLE);

  pio_shift_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (tick_en),
    .phase_tick (phase_tick)
  );

`ifdef PIO_SHIFT_OUT_MSB_FIRST_EN
  assign shift_nxt = shift_q << 1;
  assign next_bit  = shift_nxt[DATA_W-1];
  assign first_bit = bus.pio_in[DATA_W-1];
`else
  assign shift_nxt = shift_q >> 1;
  assign next_bit  = shift_nxt[0];
  assign first_bit = bus.pio_in[0];
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees
  // the pre-edge values; all registers here are small, so all are reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sent_q    <= '0;
      init_pend <= 1'b1;
      shift_q   <= '0;
      bit_cnt   <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      slatch_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_pend || bus.pio_in != sent_q) begin
            shift_q   <= bus.pio_in;
            sent_q    <= bus.pio_in;
            init_pend <= 1'b0;
            bit_cnt   <= '0;
            sdata_q   <= first_bit;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (phase_tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Data only moves on the falling sclk edge, keeping it stable
              // across the rising edge the external register samples on.
              sclk_q <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                slatch_q <= 1'b1;
                sdata_q  <= 1'b0;
                state    <= LATCH;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shift_q <= shift_nxt;
                sdata_q <= next_bit;
              end
            end
          end
        end

        LATCH: begin
          if (phase_tick) begin
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk   = sclk_q;
  assign bus.sdata  = sdata_q;
  assign bus.slatch = slatch_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pio_shift_out.sv
// Self-checking bench for pio_shift_out: a 74HC595 chain model plus a
// scoreboard of words expected to be latched, and a CLK_DIV=1 instance.
module tb_pio_shift_out;

  localparam int DW   = 10;
  localparam int CD   = 4;
  localparam int TLEN = DW * 2 * CD + CD;
`ifdef PIO_SHIFT_OUT_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic rst1_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  int            n_latch  = 0;
  bit            seen_3ff = 1'b0;

  pio_shift_out_if #(.DATA_W(DW)) bus  ();
  pio_shift_out_if #(.DATA_W(DW)) bus1 ();

  pio_shift_out #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  pio_shift_out #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk     (clk),
    .reset_n (rst1_n),
    .bus     (bus1.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== level) check(tag, 32'(bus.busy), 32'(level));
  endtask

  task automatic run_transfer();
    wait_busy(1'b1, 8, "busy_rise_timeout");
    wait_busy(1'b0, TLEN + 20, "busy_fall_timeout");
    @(negedge clk);
  endtask

  // Chain model and protocol monitor, sampled mid-cycle.
  logic [DW-1:0] sr;
  logic [DW-1:0] front;
  logic [DW-1:0] popped;
  int            nbits, busy_len, latch_len, cyc, rise_cyc;
  bit            first_sclk;
  logic          sclk_q, sdata_q, slatch_q, busy_q;

  always @(negedge clk) begin
    if (!reset_n) begin
      sr = '0; nbits = 0; busy_len = 0; latch_len = 0; first_sclk = 1'b0;
      sclk_q = 1'b0; sdata_q = 1'b0; slatch_q = 1'b0; busy_q = 1'b0;
    end else begin
      cyc++;
      if (bus.busy && !busy_q) begin
        busy_len = 0; rise_cyc = cyc; first_sclk = 1'b1;
      end
      if (bus.busy) busy_len++;
      if (!bus.busy && busy_q) check("busy_len", 32'(busy_len), 32'(TLEN));

      if (bus.sclk && !sclk_q) begin
        if (first_sclk) begin
          check("sclk_latency", 32'(cyc - rise_cyc), 32'(CD));
          first_sclk = 1'b0;
        end
        if (exp_q.size() > 0 && nbits < DW) begin
          front = exp_q[0];
          check("sdata_bit", 32'(bus.sdata),
                32'(MSB_FIRST ? front[DW-1-nbits] : front[nbits]));
        end
        sr = MSB_FIRST ? {sr[DW-2:0], bus.sdata} : {bus.sdata, sr[DW-1:1]};
        nbits++;
      end
      if (bus.sclk && bus.sdata != sdata_q) check("sdata_while_sclk_high", 32'd1, 32'd0);

      if (bus.slatch && !slatch_q) begin
        n_latch++;
        latch_len = 0;
        check("latch_bits", 32'(nbits), 32'(DW));
        nbits = 0;
        if (sr == 10'h3FF) seen_3ff = 1'b1;
        if (exp_q.size() == 0) begin
          check("stray_latch", 32'(sr), 32'hFFFF_FFFF);
        end else begin
          popped = exp_q.pop_front();
          check("latched_word", 32'(sr), 32'(popped));
        end
      end
      if (bus.slatch) latch_len++;
      if (!bus.slatch && slatch_q) check("latch_len", 32'(latch_len), 32'(CD));

      assert (!(bus.sclk && bus.slatch)) else check("sclk_slatch_overlap", 32'd1, 32'd0);

      sclk_q = bus.sclk; sdata_q = bus.sdata; slatch_q = bus.slatch; busy_q = bus.busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int act;
    reset_n     = 1'b0;
    rst1_n      = 1'b0;
    bus.pio_in  = '0;
    bus1.pio_in = 10'h200;

    // 1: reset state, then the forced initial transfer of zero.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.sclk, bus.sdata, bus.slatch, bus.busy}), 32'd0);
    exp_q.push_back(10'h000);
    reset_n = 1'b1;
    @(negedge clk);
    check("trigger_busy", 32'(bus.busy), 32'd1);
    check("trigger_sclk_low", 32'(bus.sclk), 32'd0);
    wait_busy(1'b0, TLEN + 20, "busy_fall_timeout");
    repeat (20) @(negedge clk);
    check("t1_latch_count", 32'(n_latch), 32'd1);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // 2: single change delivered.
    bus.pio_in = 10'h2A5;
    exp_q.push_back(10'h2A5);
    run_transfer();
    check("t2_latch_count", 32'(n_latch), 32'd2);

    // 3: intermediate value dropped, final value delivered.
    bus.pio_in = 10'h001;
    exp_q.push_back(10'h001);
    wait_busy(1'b1, 8, "busy_rise_timeout");
    repeat (10) @(negedge clk);
    bus.pio_in = 10'h3FF;
    repeat (10) @(negedge clk);
    bus.pio_in = 10'h155;
    exp_q.push_back(10'h155);
    wait_busy(1'b0, TLEN + 20, "busy_fall_timeout");
    run_transfer();
    repeat (10) @(negedge clk);
    check("t3_latch_count", 32'(n_latch), 32'd4);
    check("t3_no_3ff", 32'(seen_3ff), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: reset mid-transfer (sclk and sdata both high at this point).
    bus.pio_in = 10'h1FB;
    exp_q.push_back(10'h1FB);
    wait_busy(1'b1, 8, "busy_rise_timeout");
    repeat (29) @(negedge clk);
    check("t4_pre_reset_sclk", 32'(bus.sclk), 32'd1);
    base = n_latch;
    #1 reset_n = 1'b0;
    #1 check("t4_async_reset", 32'({bus.sclk, bus.sdata, bus.slatch, bus.busy}), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_no_latch_in_reset", 32'(n_latch), 32'(base));
    reset_n = 1'b1;
    run_transfer();
    repeat (10) @(negedge clk);
    check("t4_latch_count", 32'(n_latch), 32'(base + 1));
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: long idle with a stable input.
    base = n_latch;
    act  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.sclk || bus.slatch || bus.busy) act++;
    end
    check("t6_idle_activity", 32'(act), 32'd0);
    check("t6_latch_count", 32'(n_latch), 32'(base));

    // 5: CLK_DIV=1 instance, 10'h200 sent after reset release.
    begin
      int            blen, nb, lcount, llen;
      logic [DW-1:0] stream, sr1, word1;
      logic          sclk_p, slat_p;
      bit            done;
      blen = 0; nb = 0; lcount = 0; llen = 0;
      stream = '0; sr1 = '0; word1 = '0;
      sclk_p = 1'b0; slat_p = 1'b0; done = 1'b0;
      @(negedge clk);
      rst1_n = 1'b1;
      for (int c = 0; c < 80 && !done; c++) begin
        @(negedge clk);
        if (bus1.busy) blen++;
        if (bus1.sclk && !sclk_p) begin
          if (nb < DW) stream[nb] = bus1.sdata;
          sr1 = MSB_FIRST ? {sr1[DW-2:0], bus1.sdata} : {bus1.sdata, sr1[DW-1:1]};
          nb++;
        end
        if (bus1.slatch && !slat_p) begin
          lcount++;
          word1 = sr1;
        end
        if (bus1.slatch) llen++;
        if (bus1.sclk && bus1.slatch) check("t5_overlap", 32'd1, 32'd0);
        if (blen > 0 && !bus1.busy) done = 1'b1;
        sclk_p = bus1.sclk;
        slat_p = bus1.slatch;
      end
      check("t5_done", 32'(done), 32'd1);
      check("t5_busy_len", 32'(blen), 32'd21);
      check("t5_bits", 32'(nb), 32'(DW));
      check("t5_first_bit", 32'(stream[0]), 32'(MSB_FIRST));
      check("t5_stream", 32'(stream), MSB_FIRST ? 32'h001 : 32'h200);
      check("t5_latches", 32'(lcount), 32'd1);
      check("t5_latch_len", 32'(llen), 32'd1);
      check("t5_word", 32'(word1), 32'h200);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
